cache_ctrl_unit: RTL and testbench

- Cache-control slave directly downstream of the front-end's ctrl_valid/ctrl_addr/ctrl_rdata/ctrl_ready port.
- Holds hit/miss performance counters, write-through-buffer status and a software-triggered invalidate.
- Event pulses come from the cache-memory stage. The invalidate pulse goes back to cache-memory to clear the valid bits.

---
 rtl/cache_ctrl_unit_pkg.sv | 30 +++
 rtl/cache_ctrl_unit_if.sv | 29 ++
 rtl/cache_sat_counter.sv | 34 +++
 rtl/cache_ctrl_unit.sv | 118 +++++++++++
 tb/tb_cache_ctrl_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_ctrl_unit_pkg.sv
// -----------------------------------------------------------------------------
// cache_ctrl_unit_pkg
// Shared definitions for the cache control slave: the control-port address
// width, the register map offsets and the number of performance counters.
// -----------------------------------------------------------------------------
package cache_ctrl_unit_pkg;

  localparam int CTRL_ADDR_W = 4;
  localparam int NUM_CNT     = 6;

  // Register map of the control port. Offsets 0..5 double as counter indices.
  typedef enum logic [CTRL_ADDR_W-1:0] {
    CTRL_RD_HIT     = 4'd0,
    CTRL_RD_MISS    = 4'd1,
    CTRL_WR_HIT     = 4'd2,
    CTRL_WR_MISS    = 4'd3,
    CTRL_HIT        = 4'd4,
    CTRL_MISS       = 4'd5,
    CTRL_CNT_RST    = 4'd6,
    CTRL_INVALIDATE = 4'd7,
    CTRL_WTB_EMPTY  = 4'd8,
    CTRL_WTB_FULL   = 4'd9
  } ctrl_reg_e;

  // True for the offsets that map directly onto a counter.
  function automatic logic is_counter_reg(input logic [CTRL_ADDR_W-1:0] a);
    return (a < 4'(NUM_CNT));
  endfunction

endpackage

// File: rtl/cache_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// cache_ctrl_unit_if
// Control-port bundle between the cache front-end (master) and the control
// slave.
//   valid : request, held by the master until ready
//   addr  : register select, stable while valid
//   rdata : read data, meaningful while ready=1, held afterwards
//   ready : one-cycle completion pulse
// -----------------------------------------------------------------------------
interface cache_ctrl_unit_if #(
  parameter int DATA_W = 32
) ();

  logic                                       valid;
  logic [cache_ctrl_unit_pkg::CTRL_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]                          rdata;
  logic                                       ready;

  modport master (
    output valid, addr,
    input  rdata, ready
  );

  modport slave (
    input  valid, addr,
    output rdata, ready
  );

endinterface

// File: rtl/cache_sat_counter.sv
// -----------------------------------------------------------------------------
// cache_sat_counter
// Saturating event counter with synchronous clear.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset, count -> 0
//   i_clear  : clear the count; takes priority over i_incr
//   i_incr   : add one on this edge unless already at all-ones
//   o_count  : current count
// -----------------------------------------------------------------------------
module cache_sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_incr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_incr && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_ctrl_unit.sv
// -----------------------------------------------------------------------------
// cache_ctrl_unit
// Cache control slave: hit/miss performance counters, write-through-buffer
// status reads and a software-triggered invalidate pulse.
//   i_clk          : clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   bus            : control port (valid/addr in, rdata/ready out)
//   i_read_hit     : read-hit event pulse from cache memory
//   i_read_miss    : read-miss event pulse
//   i_write_hit    : write-hit event pulse
//   i_write_miss   : write-miss event pulse
//   i_wtb_empty    : write-through buffer empty level
//   i_wtb_full     : write-through buffer full level
//   o_invalidate   : one-cycle pulse clearing all cache valid bits
// -----------------------------------------------------------------------------
module cache_ctrl_unit
  import cache_ctrl_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 32,
  parameter int CTRL_CNT = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  cache_ctrl_unit_if.slave        bus,
  input  logic                    i_read_hit,
  input  logic                    i_read_miss,
  input  logic                    i_write_hit,
  input  logic                    i_write_miss,
  input  logic                    i_wtb_empty,
  input  logic                    i_wtb_full,
  output logic                    o_invalidate
);

  genvar gi;

  logic              r_ready;
  logic [DATA_W-1:0] r_rdata;
  logic              r_invalidate;

  logic              w_accept;
  logic [DATA_W-1:0] w_rdata_next;
  logic [NUM_CNT-1:0] w_incr;
  logic [CNT_W-1:0]  w_count [NUM_CNT];

  // A request is taken only while no completion is being presented, so a
  // valid still high during the ready cycle is not a second acceptance.
  assign w_accept = bus.valid && !r_ready;

  // Increment strobes indexed by register offset.
  assign w_incr[CTRL_RD_HIT]  = i_read_hit;
  assign w_incr[CTRL_RD_MISS] = i_read_miss;
  assign w_incr[CTRL_WR_HIT]  = i_write_hit;
  assign w_incr[CTRL_WR_MISS] = i_write_miss;
  assign w_incr[CTRL_HIT]     = i_read_hit  | i_write_hit;
  assign w_incr[CTRL_MISS]    = i_read_miss | i_write_miss;

  generate
    if (CTRL_CNT != 0) begin : g_cnt
      logic w_cnt_clear;

      // Clear beats any event on the same edge.
      assign w_cnt_clear = w_accept && (bus.addr == CTRL_CNT_RST);

      for (gi = 0; gi < NUM_CNT; gi++) begin : g_ctr
        cache_sat_counter #(
          .W (CNT_W)
        ) u_ctr (
          .i_clk   (i_clk),
          .i_rst_n (i_rst_n),
          .i_clear (w_cnt_clear),
          .i_incr  (w_incr[gi]),
          .o_count (w_count[gi])
        );
      end
    end else begin : g_no_cnt
      // Event inputs have no consumer without counters.
      logic w_unused_events;
      assign w_unused_events = |w_incr;

      for (gi = 0; gi < NUM_CNT; gi++) begin : g_zero
        assign w_count[gi] = '0;
      end
    end
  endgenerate

  // Read decode. Counter values are the pre-increment ones because the
  // counters update on the same edge that registers the read data.
  always_comb begin
    w_rdata_next = '0;
    if (is_counter_reg(bus.addr)) begin
      w_rdata_next[CNT_W-1:0] = w_count[bus.addr[2:0]];
    end else if (bus.addr == CTRL_WTB_EMPTY) begin
      w_rdata_next[0] = i_wtb_empty;
    end else if (bus.addr == CTRL_WTB_FULL) begin
      w_rdata_next[0] = i_wtb_full;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready      <= 1'b0;
      r_rdata      <= '0;
      r_invalidate <= 1'b0;
    end else begin
      r_ready      <= w_accept;
      r_invalidate <= w_accept && (bus.addr == CTRL_INVALIDATE);
      if (w_accept) begin
        r_rdata <= w_rdata_next;
      end
    end
  end

  assign bus.ready    = r_ready;
  assign bus.rdata    = r_rdata;
  assign o_invalidate = r_invalidate;

endmodule

// File: tb/tb_cache_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_unit
// Drives two instances (counters on with 4-bit counters, counters off) with the
// same control-port and event stimulus. A reference model predicts each
// response and queues it; a monitor pops and compares on every ready.
// -----------------------------------------------------------------------------
module tb_cache_ctrl_unit;
  import cache_ctrl_unit_pkg::*;

  localparam int SAT = 15;  // 2^4 - 1 for the counter-enabled instance

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rh = 1'b0, rm = 1'b0, wh = 1'b0, wm = 1'b0;
  logic we = 1'b0, wf = 1'b0;
  logic inv1, inv0;

  cache_ctrl_unit_if #(.DATA_W(32)) bus1 ();
  cache_ctrl_unit_if #(.DATA_W(32)) bus0 ();

  always #5 clk = ~clk;

  cache_ctrl_unit #(.DATA_W(32), .CNT_W(4), .CTRL_CNT(1)) dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .bus          (bus1),
    .i_read_hit   (rh),
    .i_read_miss  (rm),
    .i_write_hit  (wh),
    .i_write_miss (wm),
    .i_wtb_empty  (we),
    .i_wtb_full   (wf),
    .o_invalidate (inv1)
  );

  cache_ctrl_unit #(.DATA_W(32), .CNT_W(32), .CTRL_CNT(0)) dut0 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .bus          (bus0),
    .i_read_hit   (rh),
    .i_read_miss  (rm),
    .i_write_hit  (wh),
    .i_write_miss (wm),
    .i_wtb_empty  (we),
    .i_wtb_full   (wf),
    .o_invalidate (inv0)
  );

  typedef struct {
    int          cyc;
    logic [31:0] r1;
    logic [31:0] r0;
    logic        inv;
  } exp_t;

  exp_t        q[$];
  exp_t        mx;
  int          m_cnt[6];
  logic        m_ready = 1'b0;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] last1 = '0;
  logic [31:0] last0 = '0;
  logic        prev_v = 1'b0;
  logic [3:0]  prev_a = '0;
  logic        g_we = 1'b0, g_wf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bump(input int i, input logic ev);
    if (ev) m_cnt[i] = (m_cnt[i] < SAT) ? m_cnt[i] + 1 : SAT;
  endtask

  // One clock of stimulus; the model predicts what the coming edge does.
  task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] ev,
                       input logic e, input logic f);
    exp_t x;
    logic acc;
    @(negedge clk);
    bus1.valid = v; bus0.valid = v;
    bus1.addr  = a; bus0.addr  = a;
    {wm, wh, rm, rh} = ev;
    we = e; wf = f;
    acc = v && !m_ready;
    if (acc) begin
      x.cyc = cyc + 1;
      x.r1  = '0;
      x.r0  = '0;
      x.inv = (a == 4'd7);
      if (a < 4'd6) x.r1 = 32'(m_cnt[a]);
      else if (a == 4'd8) begin x.r1 = 32'(e); x.r0 = 32'(e); end
      else if (a == 4'd9) begin x.r1 = 32'(f); x.r0 = 32'(f); end
      q.push_back(x);
    end
    if (acc && a == 4'd6) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      bump(0, ev[0]);
      bump(1, ev[1]);
      bump(2, ev[2]);
      bump(3, ev[3]);
      bump(4, ev[0] | ev[2]);
      bump(5, ev[1] | ev[3]);
    end
    m_ready = acc;
    prev_v  = v;
    prev_a  = a;
  endtask

  // Request: valid for the accept cycle and the ready cycle, then released.
  task automatic req(input logic [3:0] a, input logic [3:0] ev);
    cycle(1'b1, a, ev, g_we, g_wf);
    cycle(1'b1, a, 4'b0000, g_we, g_wf);
  endtask

  task automatic idle(input logic [3:0] ev);
    cycle(1'b0, 4'd0, ev, g_we, g_wf);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.ready || bus0.ready) begin
        if (q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          mx = q.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(mx.cyc));
          chk("ready_dut1", 32'(bus1.ready), 32'd1);
          chk("ready_dut0", 32'(bus0.ready), 32'd1);
          chk("rdata_dut1", bus1.rdata, mx.r1);
          chk("rdata_dut0", bus0.rdata, mx.r0);
          chk("inval_dut1", 32'(inv1), 32'(mx.inv));
          chk("inval_dut0", 32'(inv0), 32'(mx.inv));
          last1 = mx.r1;
          last0 = mx.r0;
        end
      end else begin
        chk("inval_idle_dut1", 32'(inv1), 32'd0);
        chk("inval_idle_dut0", 32'(inv0), 32'd0);
        chk("rdata_hold_dut1", bus1.rdata, last1);
        chk("rdata_hold_dut0", bus0.rdata, last0);
      end
    end
  end

  initial begin
    logic       v;
    logic [3:0] a;
    logic [3:0] ev;

    bus1.valid = 1'b0; bus0.valid = 1'b0;
    bus1.addr  = '0;   bus0.addr  = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(bus1.ready | bus0.ready), 32'd0);
    chk("reset_rdata1", bus1.rdata, 32'd0);
    chk("reset_rdata0", bus0.rdata, 32'd0);
    chk("reset_inval", 32'(inv1 | inv0), 32'd0);
    rst_n = 1'b1;

    // Counters read zero after reset.
    for (int i = 0; i < 6; i++) req(4'(i), 4'b0000);

    // Mixed hit/miss events then counter reads.
    for (int i = 0; i < 3; i++) idle(4'b0001);
    for (int i = 0; i < 2; i++) idle(4'b1000);
    req(4'd0, 4'b0000);
    req(4'd3, 4'b0000);
    req(4'd4, 4'b0000);
    req(4'd5, 4'b0000);

    // Saturation, then clear winning over a same-cycle event.
    req(4'd6, 4'b0000);
    for (int i = 0; i < 20; i++) idle(4'b0010);
    req(4'd1, 4'b0000);
    req(4'd6, 4'b0010);
    req(4'd1, 4'b0000);

    // Valid held at invalidate for five cycles.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'd7, 4'b0000, g_we, g_wf);
    idle(4'b0000);
    idle(4'b0000);

    // Write-through status and an unmapped offset.
    g_we = 1'b1; g_wf = 1'b0;
    req(4'd8, 4'b0000);
    req(4'd9, 4'b0000);
    req(4'd12, 4'b0000);
    g_we = 1'b0; g_wf = 1'b1;
    req(4'd8, 4'b0000);
    req(4'd9, 4'b0000);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      v = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      if (prev_v && v) a = prev_a;
      for (int b = 0; b < 4; b++) ev[b] = ($urandom_range(0, 2) == 0);
      g_we = 1'($urandom_range(0, 1));
      g_wf = 1'($urandom_range(0, 1));
      cycle(v, a, ev, g_we, g_wf);
    end
    idle(4'b0000);
    idle(4'b0000);

    // Reset during the ready cycle of an accepted request.
    for (int i = 0; i < 4; i++) idle(4'b0101);
    cycle(1'b1, 4'd4, 4'b0000, g_we, g_wf);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready1", 32'(bus1.ready), 32'd0);
    chk("midrst_ready0", 32'(bus0.ready), 32'd0);
    chk("midrst_rdata1", bus1.rdata, 32'd0);
    chk("midrst_rdata0", bus0.rdata, 32'd0);
    chk("midrst_inval", 32'(inv1 | inv0), 32'd0);
    q.delete();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ready = 1'b0;
    prev_v  = 1'b0;
    last1   = '0;
    last0   = '0;
    bus1.valid = 1'b0; bus0.valid = 1'b0;
    {wm, wh, rm, rh} = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req(4'd4, 4'b0000);
    req(4'd0, 4'b0000);
    req(4'd7, 4'b0000);

    // Drain.
    for (int i = 0; i < 4; i++) idle(4'b0000);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
